// File: rtl/picomips_pkg.sv
// Shared types and defaults for the picoMIPS input path.
package picomips_pkg;

  localparam int unsigned SW_WIDTH = 8;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } btn_state_t;

  typedef enum logic {
    COORD_X = 1'b0,
    COORD_Y = 1'b1
  } coord_tag_t;

  function automatic coord_tag_t next_tag(input coord_tag_t t);
    return (t == COORD_X) ? COORD_Y : COORD_X;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-bit 2-flop synchroniser plus counter-based debouncer producing a stable level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable
);

  localparam logic [7:0] LIMIT = 8'(DEBOUNCE_CYCLES - 1);

  logic       meta_q;
  logic       sync_q;
  logic       stable_q;
  logic [7:0] cnt_q;
  logic [1:0] prime_q;

  // Until the synchroniser has filled, stable tracks the input directly so a
  // button held through reset is seen as already pressed rather than as a new edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      prime_q  <= '0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      if (prime_q != 2'd3) begin
        prime_q  <= prime_q + 2'd1;
        stable_q <= sync_q;
        cnt_q    <= '0;
      end else if (sync_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LIMIT) begin
        stable_q <= sync_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/sw_input_capture.sv
// Switch/button capture: one-shot press detection feeding a 2-entry X/Y-tagged FIFO.
// Define SW_INPUT_DEBOUNCE_EN to insert the button debouncer; otherwise stable = sw8_s.
module sw_input_capture
  import picomips_pkg::*;
#(
  parameter int unsigned WIDTH           = SW_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] SW,
  input  logic                    SW8,
  output logic signed [WIDTH-1:0] rd_data,
  output logic                    rd_is_y,
  output logic                    rd_valid,
  input  logic                    rd_ack,
  output logic                    overflow
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_cfg_check
    $error("DEBOUNCE_CYCLES must be in 1..255");
  end

  localparam logic [2:0] ARM_DONE = 3'd4;

  logic signed [WIDTH-1:0] sw_meta_q;
  logic signed [WIDTH-1:0] sw_s;
  logic                    stable;

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_q <= '0;
      sw_s      <= '0;
    end else begin
      sw_meta_q <= SW;
      sw_s      <= sw_meta_q;
    end
  end

`ifdef SW_INPUT_DEBOUNCE_EN
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .reset (reset),
    .din   (SW8),
    .stable(stable)
  );
`else
  logic sw8_meta_q;
  logic sw8_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sw8_meta_q <= 1'b0;
      sw8_s      <= 1'b0;
    end else begin
      sw8_meta_q <= SW8;
      sw8_s      <= sw8_meta_q;
    end
  end

  assign stable = sw8_s;
`endif

  logic [2:0] arm_q;
  logic       armed;
  btn_state_t state_q;
  logic       press;

  assign armed = (arm_q == ARM_DONE);
  assign press = armed && (state_q == RELEASED) && stable;

  // While arming after reset the FSM copies the level, so a held button never pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      arm_q   <= '0;
      state_q <= RELEASED;
    end else if (!armed) begin
      arm_q   <= arm_q + 3'd1;
      state_q <= stable ? PRESSED : RELEASED;
    end else begin
      unique case (state_q)
        RELEASED: if (stable)  state_q <= PRESSED;
        PRESSED:  if (!stable) state_q <= RELEASED;
      endcase
    end
  end

  logic signed [WIDTH-1:0] data_mem [2];
  coord_tag_t              tag_mem  [2];
  logic                    wr_ptr_q;
  logic                    rd_ptr_q;
  logic [1:0]              count_q;
  coord_tag_t              tag_q;
  coord_tag_t              last_tag_q;
  logic signed [WIDTH-1:0] last_data_q;
  logic                    overflow_q;
  logic                    full;
  logic                    do_pop;
  logic                    do_push;
  logic                    drop;

  assign full    = (count_q == 2'd2);
  assign do_pop  = rd_ack && (count_q != 2'd0);
  assign do_push = press && (!full || do_pop);
  assign drop    = press && full && !do_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        data_mem[i] <= '0;
        tag_mem[i]  <= COORD_X;
      end
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      tag_q       <= COORD_X;
      last_tag_q  <= COORD_X;
      last_data_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (press) tag_q <= next_tag(tag_q);
      if (drop) overflow_q <= 1'b1;
      if (do_push) begin
        data_mem[wr_ptr_q] <= sw_s;
        tag_mem[wr_ptr_q]  <= tag_q;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      // Popped entry is kept so the outputs hold their last value once empty.
      if (do_pop) begin
        last_data_q <= data_mem[rd_ptr_q];
        last_tag_q  <= tag_mem[rd_ptr_q];
        rd_ptr_q    <= ~rd_ptr_q;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_valid = (count_q != 2'd0);
  assign rd_data  = rd_valid ? data_mem[rd_ptr_q] : last_data_q;
  assign rd_is_y  = ((rd_valid ? tag_mem[rd_ptr_q] : last_tag_q) == COORD_Y);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_sw_input_capture.sv
// Scoreboard bench for sw_input_capture: directed presses, monitor checks every pop.
module tb_sw_input_capture;

  localparam int W = 8;
  localparam int D = 4;
`ifdef SW_INPUT_DEBOUNCE_EN
  localparam int LAT = D + 3;
`else
  localparam int LAT = 3;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic signed [W-1:0] SW;
  logic                SW8;
  logic signed [W-1:0] rd_data;
  logic                rd_is_y;
  logic                rd_valid;
  logic                rd_ack;
  logic                overflow;

  int vectors     = 0;
  int miscompares = 0;
  logic [W:0] exp_q[$];

  always #20 clk = ~clk;

  sw_input_capture #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .SW      (SW),
    .SW8     (SW8),
    .rd_data (rd_data),
    .rd_is_y (rd_is_y),
    .rd_valid(rd_valid),
    .rd_ack  (rd_ack),
    .overflow(overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Inputs change 2 ns after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: every accepted pop must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset === 1'b0 && rd_valid === 1'b1 && rd_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_unexpected: got data=%0h is_y=%b, required no entry", rd_data, rd_is_y);
      end else begin
        check("pop_entry", {23'd0, rd_data, rd_is_y}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic press(input logic [W-1:0] val, input int width);
    SW = val;
    tick(3);
    SW8 = 1'b1;
    tick(width);
    SW8 = 1'b0;
    tick(12);
  endtask

  task automatic pop1();
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rd_ack = 1'b1;
    while (rd_valid === 1'b1 && n < 6) begin
      tick(1);
      n++;
    end
    rd_ack = 1'b0;
    check("drain_empty", {31'd0, rd_valid}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    SW     = '0;
    SW8    = 1'b0;
    rd_ack = 1'b0;

    // Reset state
    tick(2);
    check("reset_valid", {31'd0, rd_valid}, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    check("reset_data", {24'd0, rd_data}, 32'd0);
    check("reset_is_y", {31'd0, rd_is_y}, 32'd0);
    reset = 1'b0;
    tick(6);

    // First press with latency measurement, then a second press
    SW = 8'h05;
    tick(3);
    exp_q.push_back({8'h05, 1'b0});
    SW8 = 1'b1;
    n = 0;
    while (rd_valid !== 1'b1 && n < 30) begin
      tick(1);
      n++;
    end
    check("press_latency", n, LAT);
    tick(10 - LAT);
    SW8 = 1'b0;
    tick(12);
    exp_q.push_back({8'hFB, 1'b1});
    press(8'hFB, 10);
    check("two_held_valid", {31'd0, rd_valid}, 32'd1);
    drain();

    // Glitch handling
`ifdef SW_INPUT_DEBOUNCE_EN
    press(8'h33, 3);
    check("glitch_reject", {31'd0, rd_valid}, 32'd0);
    exp_q.push_back({8'h44, 1'b0});
    press(8'h44, 4);
`else
    exp_q.push_back({8'h44, 1'b0});
    press(8'h44, 1);
`endif
    check("glitch_accept", {31'd0, rd_valid}, 32'd1);
    drain();

    // Overflow: third press (tag X) is dropped, tag still toggles
    do_reset();
    tick(6);
    exp_q.push_back({8'h11, 1'b0});
    exp_q.push_back({8'h22, 1'b1});
    press(8'h11, 6);
    press(8'h22, 6);
    check("full_no_overflow", {31'd0, overflow}, 32'd0);
    press(8'h33, 6);
    check("overflow_set", {31'd0, overflow}, 32'd1);
    pop1();
    exp_q.push_back({8'h80, 1'b1});
    press(8'h80, 6);
    check("overflow_sticky", {31'd0, overflow}, 32'd1);
    drain();
    check("overflow_after_drain", {31'd0, overflow}, 32'd1);

    // Reset with an entry present empties the FIFO and clears overflow
    press(8'h7F, 6);
    check("pre_reset_valid", {31'd0, rd_valid}, 32'd1);
    do_reset();
    check("midreset_valid", {31'd0, rd_valid}, 32'd0);
    check("midreset_overflow", {31'd0, overflow}, 32'd0);
    check("midreset_data", {24'd0, rd_data}, 32'd0);
    tick(6);

    // Full FIFO, press coincident with rd_ack
    exp_q.push_back({8'h0A, 1'b0});
    exp_q.push_back({8'h0B, 1'b1});
    press(8'h0A, 6);
    press(8'h0B, 6);
    SW = 8'h0C;
    tick(3);
    SW8 = 1'b1;
    tick(LAT - 1);
    rd_ack = 1'b1;
    exp_q.push_back({8'h0C, 1'b0});
    tick(1);
    rd_ack = 1'b0;
    check("coincident_overflow", {31'd0, overflow}, 32'd0);
    tick(5);
    SW8 = 1'b0;
    tick(12);
    check("coincident_overflow_late", {31'd0, overflow}, 32'd0);
    pop1();
    check("coincident_count_two", {31'd0, rd_valid}, 32'd1);
    drain();

    // rd_ack while empty is ignored
    rd_ack = 1'b1;
    tick(3);
    rd_ack = 1'b0;
    check("empty_ack", {31'd0, rd_valid}, 32'd0);

    // Button held across reset release must not push
    SW  = 8'h5A;
    SW8 = 1'b1;
    do_reset();
    tick(15);
    check("held_reset_no_push", {31'd0, rd_valid}, 32'd0);
    SW8 = 1'b0;
    tick(12);
    check("held_release_no_push", {31'd0, rd_valid}, 32'd0);
    exp_q.push_back({8'h66, 1'b0});
    press(8'h66, 6);
    check("repress_valid", {31'd0, rd_valid}, 32'd1);
    drain();

    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
